// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        IC_LDUR    = 3'd0,
        IC_STUR    = 3'd1,
        IC_CBZ     = 3'd2,
        IC_RTYPE   = 3'd3,
        IC_ILLEGAL = 3'd4
    } instr_class_t;

    // Opcode field values (instruction bits [31:21])
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that wait on mem_ready and therefore run the stall counter
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/opdecode.sv
// Maps the 11-bit opcode field onto an instruction class.
// Latency: purely combinational.
// Backpressure: none.
module opdecode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0]  op,
    output instr_class_t instr_class
);

    // Priority decode; CBZ only looks at the top eight bits
    always_comb begin
        instr_class = IC_ILLEGAL;
        if (op == OP_LDUR) begin
            instr_class = IC_LDUR;
        end else if (op == OP_STUR) begin
            instr_class = IC_STUR;
        end else if (op[10:3] == OP_CBZ_PFX) begin
            instr_class = IC_CBZ;
        end else if ((op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_ORR)) begin
            instr_class = IC_RTYPE;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 control FSM with memory stall timeout and sticky error flags.
// Latency: CBZ 3, R-type 4, STUR 4, LDUR 5 cycles plus mem_ready wait cycles.
// Backpressure: FETCH/MEMRD/MEMWR hold on mem_ready=0; HALT after STALL_LIMIT stalls.
module multicycle_controller
    import legv8_ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic        pc_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state_out,
    output logic        instr_done,
    output logic        illegal,
    output logic        timeout
);

    localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

    state_t           state;
    state_t           state_nxt;
    instr_class_t     instr_class;
    logic [CNT_W-1:0] stall_cnt;
    logic             illegal_q;
    logic             timeout_q;
    logic             stall_expired;

    opdecode u_opdecode (
        .op          (op),
        .instr_class (instr_class)
    );

    // A completing access (mem_ready=1) always wins over the limit
    assign stall_expired = is_wait_state(state) && !mem_ready && (stall_cnt == CNT_MAX);

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)          state_nxt = ST_DECODE;
                else if (stall_expired) state_nxt = ST_HALT;
            end
            ST_DECODE: begin
                case (instr_class)
                    IC_LDUR, IC_STUR: state_nxt = ST_MEMADR;
                    IC_RTYPE:         state_nxt = ST_EXEC;
                    IC_CBZ:           state_nxt = ST_BRANCH;
                    default:          state_nxt = ST_HALT;
                endcase
            end
            ST_MEMADR: state_nxt = (instr_class == IC_STUR) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready)          state_nxt = ST_MEMWB;
                else if (stall_expired) state_nxt = ST_HALT;
            end
            ST_MEMWB: state_nxt = ST_FETCH;
            ST_MEMWR: begin
                if (mem_ready)          state_nxt = ST_FETCH;
                else if (stall_expired) state_nxt = ST_HALT;
            end
            ST_EXEC:   state_nxt = ST_ALUWB;
            ST_ALUWB:  state_nxt = ST_FETCH;
            ST_BRANCH: state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // State register, saturating stall counter and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            stall_cnt <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Non-wait states hold the counter at zero, so every wait state is entered clean
            if (is_wait_state(state) && !mem_ready) begin
                if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if ((state == ST_DECODE) && (instr_class == IC_ILLEGAL)) illegal_q <= 1'b1;
            if (stall_expired) timeout_q <= 1'b1;
        end
    end

    // Output decode: Moore on state, with pc_write/ir_write/instr_done qualified by mem_ready or zero
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM;
                reg2loc   = (instr_class == IC_STUR) || (instr_class == IC_CBZ);
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                reg2loc   = (instr_class == IC_STUR);
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                mem_write  = 1'b1;
                reg2loc    = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_op     = ALUOP_PASSB;
                reg2loc    = 1'b1;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Latency: n/a.
// Backpressure: mem_ready driven per cycle by the bench.
module tb_multicycle_controller;

    localparam int LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        reg2loc, alu_src_a, pc_src, mem_to_reg;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state_out;
    logic        instr_done, illegal, timeout;

    always #5 clk = ~clk;

    multicycle_controller #(.STALL_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg2loc    (reg2loc),
        .alu_src_a  (alu_src_a),
        .pc_src     (pc_src),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state_out  (state_out),
        .instr_done (instr_done),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after posedge; outputs are observed on negedge
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        adv();
        reset = 1'b0;
    endtask

    // {state, pc_w, ir_w, mem_rd, mem_wr, reg_w, reg2loc, src_a, pc_src, m2r, src_b, alu_op, done, illegal, timeout}
    function automatic logic [19:0] snap();
        return {state_out, pc_write, ir_write, mem_read, mem_write, reg_write, reg2loc,
                alu_src_a, pc_src, mem_to_reg, alu_src_b, alu_op, instr_done, illegal, timeout};
    endfunction

    localparam logic [19:0] SNAP_RESET   = {4'd0, 8'b00100000, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [19:0] SNAP_HALT_TO = {4'd9, 8'b00000000, 1'b0, 2'b00, 2'b00, 3'b001};
    localparam logic [19:0] SNAP_HALT_IL = {4'd9, 8'b00000000, 1'b0, 2'b00, 2'b00, 3'b010};

    // Table of single instructions run with mem_ready tied high
    typedef struct {
        logic [10:0] op;
        logic        zero;
        int          lat;
        int          regw;
        int          pcw;
        int          memw;
        int          irw;
    } vec_t;

    vec_t vecs [8];

    // Expected per-cycle trace for the random test, built from the instruction's phase list
    typedef struct {
        logic [3:0] st;
        int         rdy;     // 0/1 forced value, -1 = don't care
        logic       irw;
        logic       pcw;
        logic       pcw_zero; // pc_write follows the zero input this cycle
        logic       regw;
        logic       memw;
        logic       done;
    } ph_t;

    ph_t         trace [$];
    logic [10:0] rops [4];

    task automatic add_ph(input logic [3:0] st, input int rdy, input logic irw, input logic pcw,
                          input logic pcz, input logic regw, input logic memw, input logic done);
        ph_t p;
        p.st = st; p.rdy = rdy; p.irw = irw; p.pcw = pcw; p.pcw_zero = pcz;
        p.regw = regw; p.memw = memw; p.done = done;
        trace.push_back(p);
    endtask

    initial begin
        int lat, nrw, npw, nmw, niw, n, cls, s1, s2;
        logic done;
        logic [3:0] exp_ld [5];
        logic exp_pc;

        vecs[0] = '{op: 11'b11111000010, zero: 1'b0, lat: 5, regw: 1, pcw: 1, memw: 0, irw: 1};
        vecs[1] = '{op: 11'b11111000000, zero: 1'b0, lat: 4, regw: 0, pcw: 1, memw: 1, irw: 1};
        vecs[2] = '{op: 11'b10110100101, zero: 1'b1, lat: 3, regw: 0, pcw: 2, memw: 0, irw: 1};
        vecs[3] = '{op: 11'b10110100000, zero: 1'b0, lat: 3, regw: 0, pcw: 1, memw: 0, irw: 1};
        vecs[4] = '{op: 11'b10001011000, zero: 1'b1, lat: 4, regw: 1, pcw: 1, memw: 0, irw: 1};
        vecs[5] = '{op: 11'b11001011000, zero: 1'b0, lat: 4, regw: 1, pcw: 1, memw: 0, irw: 1};
        vecs[6] = '{op: 11'b10001010000, zero: 1'b0, lat: 4, regw: 1, pcw: 1, memw: 0, irw: 1};
        vecs[7] = '{op: 11'b10101010000, zero: 1'b1, lat: 4, regw: 1, pcw: 1, memw: 0, irw: 1};
        rops[0] = 11'b10001011000;
        rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000;
        rops[3] = 11'b10101010000;
        exp_ld  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

        op = 11'b11111000010;
        reset = 1'b1;
        zero = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        do_reset();
        settle();
        check("reset_outputs", 32'(snap()), 32'(SNAP_RESET));
        adv();

        // Table-driven single instructions
        for (int i = 0; i < 8; i++) begin
            do_reset();
            op = vecs[i].op; zero = vecs[i].zero; mem_ready = 1'b1;
            lat = 0; nrw = 0; npw = 0; nmw = 0; niw = 0; done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                settle();
                lat++;
                nrw += int'(reg_write); npw += int'(pc_write);
                nmw += int'(mem_write); niw += int'(ir_write);
                done = instr_done;
                adv();
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_reg_write", i), 32'(nrw), 32'(vecs[i].regw));
            check($sformatf("vec%0d_pc_write", i), 32'(npw), 32'(vecs[i].pcw));
            check($sformatf("vec%0d_mem_write", i), 32'(nmw), 32'(vecs[i].memw));
            check($sformatf("vec%0d_ir_write", i), 32'(niw), 32'(vecs[i].irw));
        end

        // LDUR state walk, zero wait states
        do_reset();
        op = 11'b11111000010; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("ldur_state%0d", i), 32'(state_out), 32'(exp_ld[i]));
            if (i == 4) check("ldur_wb", 32'({reg_write, mem_to_reg, instr_done}), 32'(3'b111));
            adv();
        end

        // ADD with three FETCH wait cycles
        do_reset();
        op = 11'b10001011000;
        niw = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            check($sformatf("add_fetch%0d", i), 32'(state_out), 32'd0);
            niw += int'(ir_write);
            adv();
        end
        check("add_ir_write_once", 32'(niw), 32'd1);
        settle(); check("add_decode", 32'(state_out), 32'd1); adv();
        settle(); check("add_exec", 32'({state_out, alu_op}), 32'({4'd6, 2'b10})); adv();
        settle(); check("add_aluwb", 32'({state_out, reg_write, instr_done}), 32'({4'd7, 2'b11})); adv();

        // STUR with mem_ready stuck low: counter walks 0..LIMIT, HALT on the cycle it sits at LIMIT
        do_reset();
        op = 11'b11111000000; mem_ready = 1'b1;
        adv(); adv(); adv();
        mem_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (state_out != 4'd5) break;
            n++;
            adv();
        end
        check("stur_memwr_cycles", 32'(n), 32'(LIMIT + 1));
        check("stur_halt_timeout", 32'(snap()), 32'(SNAP_HALT_TO));
        mem_ready = 1'b1;
        adv(); adv();
        settle();
        check("stur_halt_absorbing", 32'(snap()), 32'(SNAP_HALT_TO));
        adv();

        // mem_ready arrives on the very cycle the counter sits at LIMIT: access completes
        do_reset();
        op = 11'b11111000000; mem_ready = 1'b1;
        adv(); adv(); adv();
        mem_ready = 1'b0;
        for (int c = 0; c < LIMIT; c++) adv();
        mem_ready = 1'b1;
        settle();
        check("limit_edge_done", 32'({state_out, instr_done, timeout}), 32'({4'd5, 2'b10}));
        adv();
        settle();
        check("limit_edge_fetch", 32'({state_out, timeout}), 32'({4'd0, 1'b0}));
        adv();

        // FETCH starved of mem_ready also times out
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (state_out != 4'd0) break;
            n++;
            adv();
        end
        check("fetch_stall_cycles", 32'(n), 32'(LIMIT + 1));
        check("fetch_timeout", 32'({state_out, timeout}), 32'({4'd9, 1'b1}));
        adv();

        // Illegal opcode, then a one-cycle reset clears it
        do_reset();
        op = 11'b11111111111; mem_ready = 1'b1;
        settle(); adv();
        settle(); check("illegal_decode", 32'(state_out), 32'd1); adv();
        settle(); check("illegal_halt", 32'(snap()), 32'(SNAP_HALT_IL)); adv();
        reset = 1'b1; adv(); reset = 1'b0; mem_ready = 1'b0;
        settle(); check("illegal_cleared", 32'(snap()), 32'(SNAP_RESET)); adv();

        // Reset during MEMRD: back to FETCH with no write-back
        do_reset();
        op = 11'b11111000010; mem_ready = 1'b1;
        adv(); adv(); adv();
        mem_ready = 1'b0;
        settle(); check("rst_memrd_state", 32'(state_out), 32'd3);
        adv();
        reset = 1'b1; mem_ready = 1'b1;
        adv();
        reset = 1'b0; mem_ready = 1'b0;
        settle(); check("rst_memrd_fetch", 32'({state_out, reg_write}), 32'({4'd0, 1'b0}));
        adv();

        // Random instruction stream with random wait states
        do_reset();
        for (int k = 0; k < 60; k++) begin
            cls = $urandom_range(0, 3);
            s1  = $urandom_range(0, 6);
            s2  = $urandom_range(0, 6);
            case (cls)
                0: op = 11'b11111000010;
                1: op = 11'b11111000000;
                2: op = {8'b10110100, 3'($urandom_range(0, 7))};
                default: op = rops[$urandom_range(0, 3)];
            endcase
            trace.delete();
            for (int i = 0; i < s1; i++) add_ph(4'd0, 0, 0, 0, 0, 0, 0, 0);
            add_ph(4'd0, 1, 1, 1, 0, 0, 0, 0);
            add_ph(4'd1, -1, 0, 0, 0, 0, 0, 0);
            case (cls)
                0: begin
                    add_ph(4'd2, -1, 0, 0, 0, 0, 0, 0);
                    for (int i = 0; i < s2; i++) add_ph(4'd3, 0, 0, 0, 0, 0, 0, 0);
                    add_ph(4'd3, 1, 0, 0, 0, 0, 0, 0);
                    add_ph(4'd4, -1, 0, 0, 0, 1, 0, 1);
                end
                1: begin
                    add_ph(4'd2, -1, 0, 0, 0, 0, 0, 0);
                    for (int i = 0; i < s2; i++) add_ph(4'd5, 0, 0, 0, 0, 0, 1, 0);
                    add_ph(4'd5, 1, 0, 0, 0, 0, 1, 1);
                end
                2: add_ph(4'd8, -1, 0, 0, 1, 0, 0, 1);
                default: begin
                    add_ph(4'd6, -1, 0, 0, 0, 0, 0, 0);
                    add_ph(4'd7, -1, 0, 0, 0, 1, 0, 1);
                end
            endcase
            while (trace.size() > 0) begin
                ph_t p;
                p = trace.pop_front();
                mem_ready = (p.rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(p.rdy);
                zero = 1'($urandom_range(0, 1));
                exp_pc = p.pcw_zero ? zero : p.pcw;
                settle();
                check($sformatf("rand%0d_st%0d", k, p.st),
                      32'({state_out, ir_write, pc_write, reg_write, mem_write, instr_done}),
                      32'({p.st, p.irw, exp_pc, p.regw, p.memw, p.done}));
                adv();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
